// File: rtl/gpio_apb_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_apb_arbiter
//
// Shares the single GPIO APB slave port between two upstream APB masters
// (typically the CPU data bus on m0 and a DMA/debug master on m1).
//
// An upstream master is requesting while it sits in its access phase
// (PSEL && PENABLE). One request is granted at a time, round-robin on ties.
// The granted request is latched and replayed downstream as a complete APB
// SETUP/ACCESS sequence. The result is handed back to the granted master only,
// as a one-cycle PREADY pulse. A watchdog aborts an ACCESS phase that never
// sees s_PREADY and returns 0xDEADBEEF with PSLVERR set.
//
// Ports
//   PCLK, PRESET            clock, asynchronous active-high reset
//   mX_PSEL/PENABLE         upstream select/enable (request = both high)
//   mX_PADDR/PWRITE/PWDATA  upstream address, direction, write data
//   mX_PRDATA               read data (shared register, valid with own PREADY)
//   mX_PREADY/PSLVERR       completion pulse and abort flag to master X
//   s_PSEL/PENABLE/PWRITE   downstream APB control
//   s_PADDR/PWDATA          downstream address and write data
//   s_PRDATA/PREADY         downstream read data and (registered) ready
//   grant                   index of the current / last granted master
//   busy                    high whenever a transfer is in progress
// -----------------------------------------------------------------------------
module gpio_apb_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              m0_PSEL,
    input  logic              m0_PENABLE,
    input  logic [ADDR_W-1:0] m0_PADDR,
    input  logic              m0_PWRITE,
    input  logic [DATA_W-1:0] m0_PWDATA,
    output logic [DATA_W-1:0] m0_PRDATA,
    output logic              m0_PREADY,
    output logic              m0_PSLVERR,

    input  logic              m1_PSEL,
    input  logic              m1_PENABLE,
    input  logic [ADDR_W-1:0] m1_PADDR,
    input  logic              m1_PWRITE,
    input  logic [DATA_W-1:0] m1_PWDATA,
    output logic [DATA_W-1:0] m1_PRDATA,
    output logic              m1_PREADY,
    output logic              m1_PSLVERR,

    output logic              s_PSEL,
    output logic              s_PENABLE,
    output logic              s_PWRITE,
    output logic [ADDR_W-1:0] s_PADDR,
    output logic [DATA_W-1:0] s_PWDATA,
    input  logic [DATA_W-1:0] s_PRDATA,
    input  logic              s_PREADY,

    output logic              grant,
    output logic              busy
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int                CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;

    logic              grant_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              req0, req1;
    logic              winner;
    logic              load;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cap_ok;
    logic              cap_abort;

    assign req0 = m0_PSEL && m0_PENABLE;
    assign req1 = m1_PSEL && m1_PENABLE;

    // A lone requester wins outright; on a tie the master that was not
    // granted last time goes first.
    assign winner = (req0 && req1) ? !last_grant_q : req1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of all others, independent of block ordering.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cap_ok    = 1'b0;
        cap_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_clr = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (s_PREADY) begin
                    cap_ok  = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cap_abort = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                // Always pass through IDLE: the served master drops PENABLE
                // and the slave's registered PREADY clears before the next
                // ACCESS can sample it.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the latched request and response registers are reset as well, so
    // the downstream bus and read data come out of reset as known zeros
    // rather than stale values from an aborted transfer.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (load) begin
                grant_q      <= winner;
                last_grant_q <= winner;
                addr_q       <= winner ? m1_PADDR  : m0_PADDR;
                write_q      <= winner ? m1_PWRITE : m0_PWRITE;
                wdata_q      <= winner ? m1_PWDATA : m0_PWDATA;
            end

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Writes capture s_PRDATA too; the master ignores it.
            if (cap_ok) begin
                rdata_q <= s_PRDATA;
                err_q   <= 1'b0;
            end else if (cap_abort) begin
                rdata_q <= ABORT_DATA;
                err_q   <= 1'b1;
            end
        end
    end

    // Downstream control decodes directly from the state register, so it
    // cannot glitch high in IDLE or RESP.
    assign s_PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    assign s_PENABLE = (state_q == ACCESS);
    assign s_PWRITE  = write_q;
    assign s_PADDR   = addr_q;
    assign s_PWDATA  = wdata_q;

    assign m0_PREADY  = (state_q == RESP) && !grant_q;
    assign m1_PREADY  = (state_q == RESP) &&  grant_q;
    assign m0_PSLVERR = m0_PREADY && err_q;
    assign m1_PSLVERR = m1_PREADY && err_q;
    assign m0_PRDATA  = rdata_q;
    assign m1_PRDATA  = rdata_q;

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpio_apb_arbiter
//
// Two upstream master drivers and a registered-PREADY GPIO slave model
// (CR at 0x0, ODR at 0x4, read-only IDR at 0x8 reflecting gpio_pins).
// Each transfer is scored by a transaction-level reference model at issue
// time: arbitration order, register-map contents, abort result and expected
// ACCESS length are pushed into queues; an independent monitor pops and
// compares whenever the DUT starts a SETUP phase or returns a PREADY.
// -----------------------------------------------------------------------------
module tb_gpio_apb_arbiter;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        int          m;
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } xfer_t;

    logic              PCLK;
    logic              PRESET;
    logic              m0_PSEL, m0_PENABLE, m0_PWRITE;
    logic [ADDR_W-1:0] m0_PADDR;
    logic [DATA_W-1:0] m0_PWDATA, m0_PRDATA;
    logic              m0_PREADY, m0_PSLVERR;
    logic              m1_PSEL, m1_PENABLE, m1_PWRITE;
    logic [ADDR_W-1:0] m1_PADDR;
    logic [DATA_W-1:0] m1_PWDATA, m1_PRDATA;
    logic              m1_PREADY, m1_PSLVERR;
    logic              s_PSEL, s_PENABLE, s_PWRITE;
    logic [ADDR_W-1:0] s_PADDR;
    logic [DATA_W-1:0] s_PWDATA, s_PRDATA;
    logic              s_PREADY;
    logic              grant, busy;

    int          checks = 0;
    int          errors = 0;
    xfer_t       setup_q[$];
    xfer_t       resp_q[$];
    logic [31:0] model_regs [0:1];
    bit          model_last;

    logic [7:0]  gpio_pins;
    int          slave_wait;
    bit          slave_dead;
    logic [31:0] slave_mem [0:1];
    int          wcnt;

    gpio_apb_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .m0_PSEL   (m0_PSEL),
        .m0_PENABLE(m0_PENABLE),
        .m0_PADDR  (m0_PADDR),
        .m0_PWRITE (m0_PWRITE),
        .m0_PWDATA (m0_PWDATA),
        .m0_PRDATA (m0_PRDATA),
        .m0_PREADY (m0_PREADY),
        .m0_PSLVERR(m0_PSLVERR),
        .m1_PSEL   (m1_PSEL),
        .m1_PENABLE(m1_PENABLE),
        .m1_PADDR  (m1_PADDR),
        .m1_PWRITE (m1_PWRITE),
        .m1_PWDATA (m1_PWDATA),
        .m1_PRDATA (m1_PRDATA),
        .m1_PREADY (m1_PREADY),
        .m1_PSLVERR(m1_PSLVERR),
        .s_PSEL    (s_PSEL),
        .s_PENABLE (s_PENABLE),
        .s_PWRITE  (s_PWRITE),
        .s_PADDR   (s_PADDR),
        .s_PWDATA  (s_PWDATA),
        .s_PRDATA  (s_PRDATA),
        .s_PREADY  (s_PREADY),
        .grant     (grant),
        .busy      (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // GPIO slave: PREADY is registered; it rises slave_wait+1 edges into
    // ACCESS, so each ACCESS phase lasts slave_wait+2 cycles.
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            s_PREADY     <= 1'b0;
            s_PRDATA     <= '0;
            wcnt         <= 0;
            slave_mem[0] <= '0;
            slave_mem[1] <= '0;
        end else begin
            s_PREADY <= 1'b0;
            if (s_PSEL && !s_PENABLE) begin
                wcnt <= slave_wait;
            end else if (s_PSEL && s_PENABLE && !s_PREADY && !slave_dead) begin
                if (wcnt == 0) begin
                    s_PREADY <= 1'b1;
                    if (s_PWRITE) begin
                        if (s_PADDR != 4'h8) slave_mem[s_PADDR[2]] <= s_PWDATA;
                    end else begin
                        s_PRDATA <= (s_PADDR == 4'h8) ? {24'h0, gpio_pins}
                                                      : slave_mem[s_PADDR[2]];
                    end
                end else begin
                    wcnt <= wcnt - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scores SETUP phases and PREADY pulses against the queues.
    initial begin
        xfer_t e;
        int    acc_cnt;
        acc_cnt = 0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                acc_cnt = 0;
            end else begin
                if (s_PSEL && !s_PENABLE) begin
                    acc_cnt = 0;
                    if (setup_q.size() == 0) begin
                        check("setup_unexpected", setup_q.size(), 1);
                    end else begin
                        e = setup_q.pop_front();
                        check("setup_grant", grant, e.m);
                        check("setup_addr", s_PADDR, e.addr);
                        check("setup_write", s_PWRITE, e.wr);
                        if (e.wr) check("setup_wdata", s_PWDATA, e.wdata);
                    end
                end
                if (s_PSEL && s_PENABLE) acc_cnt++;
                if (m0_PREADY || m1_PREADY) begin
                    if (resp_q.size() == 0) begin
                        check("resp_unexpected", resp_q.size(), 1);
                    end else begin
                        e = resp_q.pop_front();
                        check("resp_pready", {m1_PREADY, m0_PREADY}, e.m ? 2 : 1);
                        check("resp_grant", grant, e.m);
                        check("resp_pslverr", {m1_PSLVERR, m0_PSLVERR}, e.err ? (e.m ? 2 : 1) : 0);
                        if (!e.wr || e.err)
                            check("resp_prdata", e.m ? m1_PRDATA : m0_PRDATA, e.rdata);
                        check("resp_access_cycles", acc_cnt, e.acc);
                        check("resp_sbus_idle", {s_PSEL, s_PENABLE}, 0);
                    end
                end
            end
        end
    end

    // Reference model of one transfer, applied in grant order.
    task automatic model_xfer(input xfer_t t);
        xfer_t e;
        e = t;
        if (slave_dead) begin
            e.rdata = 32'hDEAD_BEEF;
            e.err   = 1'b1;
            e.acc   = TIMEOUT;
        end else begin
            e.err = 1'b0;
            e.acc = slave_wait + 2;
            e.rdata = '0;
            if (t.wr) begin
                if (t.addr != 4'h8) model_regs[t.addr[2]] = t.wdata;
            end else begin
                e.rdata = (t.addr == 4'h8) ? {24'h0, gpio_pins} : model_regs[t.addr[2]];
            end
        end
        model_last = (t.m != 0);
        setup_q.push_back(e);
        resp_q.push_back(e);
    endtask

    task automatic master_xfer(input int m, input int d, input xfer_t t);
        bit done;
        repeat (d) @(negedge PCLK);
        @(negedge PCLK);
        if (m == 0) begin
            m0_PSEL = 1'b1; m0_PENABLE = 1'b0;
            m0_PADDR = t.addr; m0_PWRITE = t.wr; m0_PWDATA = t.wdata;
        end else begin
            m1_PSEL = 1'b1; m1_PENABLE = 1'b0;
            m1_PADDR = t.addr; m1_PWRITE = t.wr; m1_PWDATA = t.wdata;
        end
        @(negedge PCLK);
        if (m == 0) m0_PENABLE = 1'b1; else m1_PENABLE = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge PCLK);
            if ((m == 0) ? m0_PREADY : m1_PREADY) done = 1'b1;
        end
        if (m == 0) begin
            m0_PSEL = 1'b0; m0_PENABLE = 1'b0; m0_PADDR = 4'hC; m0_PWDATA = $urandom;
        end else begin
            m1_PSEL = 1'b0; m1_PENABLE = 1'b0; m1_PADDR = 4'hC; m1_PWDATA = $urandom;
        end
        check("xfer_completed", done, 1);
    endtask

    function automatic xfer_t mk(input int m, input logic [3:0] addr, input logic wr,
                                 input logic [31:0] wdata);
        xfer_t t;
        t.m = m; t.addr = addr; t.wr = wr; t.wdata = wdata;
        t.rdata = '0; t.err = 1'b0; t.acc = 0;
        return t;
    endfunction

    function automatic xfer_t rand_xfer(input int m);
        logic [1:0] idx;
        idx = 2'($urandom_range(0, 2));
        return mk(m, {idx, 2'b00}, 1'($urandom_range(0, 1)), $urandom);
    endfunction

    // One round: each selected master issues one transfer after its delay.
    // Equal delays arrive together (tie -> master not granted last time);
    // otherwise the earlier master is granted while the DUT is idle and the
    // later one waits behind it.
    task automatic round(input bit h0, input bit h1, input int d0, input int d1,
                         input xfer_t t0, input xfer_t t1);
        int first;
        if (h0 && h1) first = (d0 == d1) ? (model_last ? 0 : 1) : ((d0 < d1) ? 0 : 1);
        else          first = h1 ? 1 : 0;
        if (first == 0) begin
            if (h0) model_xfer(t0);
            if (h1) model_xfer(t1);
        end else begin
            if (h1) model_xfer(t1);
            if (h0) model_xfer(t0);
        end
        fork
            begin if (h0) master_xfer(0, d0, t0); end
            begin if (h1) master_xfer(1, d1, t1); end
        join
    endtask

    task automatic apply_reset();
        PRESET = 1'b1;
        model_regs[0] = '0;
        model_regs[1] = '0;
        model_last = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    initial begin
        xfer_t a, b, c;
        bit    seen_access;

        m0_PSEL = 0; m0_PENABLE = 0; m0_PADDR = 0; m0_PWRITE = 0; m0_PWDATA = 0;
        m1_PSEL = 0; m1_PENABLE = 0; m1_PADDR = 0; m1_PWRITE = 0; m1_PWDATA = 0;
        gpio_pins = 8'h00; slave_wait = 0; slave_dead = 0;
        PRESET = 1'b1;
        #1;
        model_regs[0] = '0; model_regs[1] = '0; model_last = 1'b1;
        repeat (2) @(negedge PCLK);

        // Reset state.
        check("rst_s_ctl", {s_PSEL, s_PENABLE, s_PWRITE}, 0);
        check("rst_s_paddr", s_PADDR, 0);
        check("rst_s_pwdata", s_PWDATA, 0);
        check("rst_m_pready", {m1_PREADY, m0_PREADY, m1_PSLVERR, m0_PSLVERR}, 0);
        check("rst_prdata", m0_PRDATA, 0);
        check("rst_grant_busy", {grant, busy}, 0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // First tie after reset goes to m0; m1 reads the input pins.
        gpio_pins = 8'hA5;
        round(1, 1, 0, 0, mk(0, 4'h4, 1'b1, 32'h0000_000A), mk(1, 4'h8, 1'b0, 32'h0));
        // Repeated ties alternate.
        for (int i = 0; i < 3; i++) round(1, 1, 1, 1, rand_xfer(0), rand_xfer(1));

        // m0 write CR then read it back.
        round(1, 0, 0, 0, mk(0, 4'h0, 1'b1, 32'h0000_00FF), mk(1, 4'h0, 1'b0, 32'h0));
        round(1, 0, 0, 0, mk(0, 4'h0, 1'b0, 32'h0),         mk(1, 4'h0, 1'b0, 32'h0));
        round(0, 1, 0, 0, mk(0, 4'h0, 1'b0, 32'h0),         mk(1, 4'h4, 1'b0, 32'h0));

        // m1 streams back-to-back; m0 arrives during m1's first transfer and
        // must be served before m1's second one.
        slave_wait = 0;
        a = rand_xfer(1); b = rand_xfer(0); c = rand_xfer(1);
        model_xfer(a); model_xfer(b); model_xfer(c);
        fork
            begin master_xfer(1, 0, a); master_xfer(1, 0, c); end
            begin master_xfer(0, 2, b); end
        join

        // Randomized traffic with variable slave wait states.
        for (int i = 0; i < 40; i++) begin
            bit h0, h1;
            h0 = 1'($urandom_range(0, 1));
            h1 = h0 ? 1'($urandom_range(0, 1)) : 1'b1;
            slave_wait = $urandom_range(0, 3);
            gpio_pins  = 8'($urandom);
            round(h0, h1, $urandom_range(0, 3), $urandom_range(0, 3), rand_xfer(0), rand_xfer(1));
        end

        // Watchdog abort: slave never answers.
        slave_dead = 1'b1;
        round(1, 0, 0, 0, mk(0, 4'h0, 1'b0, 32'h0), mk(1, 4'h0, 1'b0, 32'h0));
        @(negedge PCLK);
        check("idle_after_timeout", busy, 0);
        round(0, 1, 0, 0, mk(0, 4'h0, 1'b0, 32'h0), mk(1, 4'h4, 1'b1, 32'h1234_5678));

        // Reset in the middle of ACCESS: transfer dropped, no PREADY.
        a = mk(0, 4'h0, 1'b0, 32'h0);
        setup_q.push_back(a);
        @(negedge PCLK);
        m0_PSEL = 1'b1; m0_PENABLE = 1'b0; m0_PADDR = 4'h0; m0_PWRITE = 1'b0;
        @(negedge PCLK);
        m0_PENABLE = 1'b1;
        seen_access = 1'b0;
        for (int i = 0; i < 20 && !seen_access; i++) begin
            @(negedge PCLK);
            if (s_PSEL && s_PENABLE) seen_access = 1'b1;
        end
        check("mid_reset_reached_access", seen_access, 1);
        repeat (3) @(negedge PCLK);
        #2;
        PRESET = 1'b1;
        #1;
        check("mid_reset_sbus", {s_PSEL, s_PENABLE}, 0);
        check("mid_reset_pready", {m1_PREADY, m0_PREADY}, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_prdata", m0_PRDATA, 0);
        m0_PSEL = 1'b0; m0_PENABLE = 1'b0;
        slave_dead = 1'b0;
        apply_reset();

        // After reset the tie goes to m0 again.
        slave_wait = 1;
        round(1, 1, 0, 0, mk(0, 4'h4, 1'b1, 32'h0000_0055), mk(1, 4'h4, 1'b0, 32'h0));

        repeat (5) @(negedge PCLK);
        check("setup_q_drained", setup_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        check("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
